// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - CORDIC control-word bit map, register word indices and reset word
package cordic_pkg;

  // Host-owned control bits [15:0]
  localparam int unsigned CTRL_START          = 0;
  localparam int unsigned CTRL_STOP           = 1;
  localparam int unsigned CTRL_ROT_MODE       = 2;
  localparam int unsigned CTRL_ROT_SYS        = 3;
  localparam int unsigned CTRL_ITER_L         = 4;
  localparam int unsigned CTRL_ITER_H         = 8;
  localparam int unsigned CTRL_INT_EN         = 9;
  localparam int unsigned CTRL_X_OV_STOP_EN   = 10;
  localparam int unsigned CTRL_Y_OV_STOP_EN   = 11;
  localparam int unsigned CTRL_Z_OV_STOP_EN   = 12;
  localparam int unsigned CTRL_Z_OV_REP_EN    = 13;

  // Hardware-owned flag bits [31:16]
  localparam int unsigned FLAG_READY          = 16;
  localparam int unsigned FLAG_X_OV           = 17;
  localparam int unsigned FLAG_Y_OV           = 18;
  localparam int unsigned FLAG_Z_OV           = 19;
  localparam int unsigned FLAG_ELAPS_L        = 20;
  localparam int unsigned FLAG_ELAPS_H        = 24;
  localparam int unsigned FLAG_OV_ITER_L      = 25;
  localparam int unsigned FLAG_OV_ITER_H      = 29;

  localparam logic [31:0] CTRL_RESET_WORD = 32'h0001_3FF0;

  typedef enum logic [2:0] {
    IDX_CTRL    = 3'd0,
    IDX_XIN     = 3'd1,
    IDX_YIN     = 3'd2,
    IDX_ZIN     = 3'd3,
    IDX_XRES    = 3'd4,
    IDX_YRES    = 3'd5,
    IDX_ZRES    = 3'd6,
    IDX_IRQSTAT = 3'd7
  } reg_idx_e;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_RESP = 1'b1
  } bus_state_e;

  function automatic logic is_result_idx(reg_idx_e idx);
    return (idx == IDX_XRES) || (idx == IDX_YRES) || (idx == IDX_ZRES);
  endfunction

endpackage

// File: rtl/cordic_bus_regs.sv
// rtl/cordic_bus_regs.sv - host register bank for the CORDIC controller
// Single-outstanding request/response bus, CTRL/operand storage, result snapshot and sticky irq.
module cordic_bus_regs
  import cordic_pkg::*;
#(
  parameter int p_WIDTH      = 32,
  parameter int p_ADDR_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    reqValid,
  output logic                    reqReady,
  input  logic                    reqWrite,
  input  logic [p_ADDR_WIDTH-1:0] reqAddr,
  input  logic [p_WIDTH-1:0]      reqWdata,
  output logic                    rspValid,
  input  logic                    rspReady,
  output logic [p_WIDTH-1:0]      rspRdata,
  output logic                    rspErr,
  output logic [31:0]             controlRegisterInput,
  output logic [p_WIDTH-1:0]      xInput,
  output logic [p_WIDTH-1:0]      yInput,
  output logic [p_WIDTH-1:0]      zInput,
  input  logic [31:0]             controlRegisterOutput,
  input  logic                    controlRegisterWriteEnable,
  input  logic [p_WIDTH-1:0]      xResult,
  input  logic [p_WIDTH-1:0]      yResult,
  input  logic [p_WIDTH-1:0]      zResult,
  input  logic                    interrupt,
  output logic                    irq
);

  bus_state_e         state_q, state_d;
  logic [31:0]        ctrl_q, ctrl_d;
  logic [p_WIDTH-1:0] xin_q, xin_d;
  logic [p_WIDTH-1:0] yin_q, yin_d;
  logic [p_WIDTH-1:0] zin_q, zin_d;
  logic [p_WIDTH-1:0] xres_q, xres_d;
  logic [p_WIDTH-1:0] yres_q, yres_d;
  logic [p_WIDTH-1:0] zres_q, zres_d;
  logic               pending_q, pending_d;
  logic [p_WIDTH-1:0] rdata_q, rdata_d;
  logic               err_q, err_d;

  logic               accept;
  logic               wr_acc;
  logic               wr_err;
  logic               snap;
  reg_idx_e           req_idx;
  logic [p_WIDTH-1:0] rd_word;
  logic               unused_addr_bits;

  assign req_idx          = reg_idx_e'(reqAddr[4:2]);
  assign unused_addr_bits = ^reqAddr[1:0];

  always_comb begin
    state_d  = state_q;
    reqReady = 1'b0;
    rspValid = 1'b0;
    accept   = 1'b0;
    case (state_q)
      BUS_IDLE: begin
        reqReady = 1'b1;
        if (reqValid) begin
          accept  = 1'b1;
          state_d = BUS_RESP;
        end
      end
      BUS_RESP: begin
        rspValid = 1'b1;
        if (rspReady) begin
          state_d = BUS_IDLE;
        end
      end
      default: state_d = BUS_IDLE;
    endcase
  end

  assign wr_acc = accept && reqWrite;
  assign wr_err = wr_acc && is_result_idx(req_idx);
  assign snap   = controlRegisterWriteEnable && controlRegisterOutput[FLAG_READY];

  always_comb begin
    rd_word = '0;
    case (req_idx)
      IDX_CTRL:    rd_word = p_WIDTH'(ctrl_q);
      IDX_XIN:     rd_word = xin_q;
      IDX_YIN:     rd_word = yin_q;
      IDX_ZIN:     rd_word = zin_q;
      IDX_XRES:    rd_word = xres_q;
      IDX_YRES:    rd_word = yres_q;
      IDX_ZRES:    rd_word = zres_q;
      IDX_IRQSTAT: rd_word = p_WIDTH'(pending_q);
      default:     rd_word = '0;
    endcase
  end

  // Response is captured at acceptance so later hardware updates cannot disturb it.
  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept) begin
      err_d   = wr_err;
      rdata_d = reqWrite ? '0 : rd_word;
    end
  end

  // Write-back first, then the host low half on top: a host START/STOP wins a collision.
  always_comb begin
    ctrl_d = ctrl_q;
    xin_d  = xin_q;
    yin_d  = yin_q;
    zin_d  = zin_q;
    if (controlRegisterWriteEnable) begin
      ctrl_d = controlRegisterOutput;
    end
    if (wr_acc) begin
      case (req_idx)
        IDX_CTRL: ctrl_d[15:0] = reqWdata[15:0];
        IDX_XIN:  xin_d = reqWdata;
        IDX_YIN:  yin_d = reqWdata;
        IDX_ZIN:  zin_d = reqWdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    xres_d = xres_q;
    yres_d = yres_q;
    zres_d = zres_q;
    if (snap) begin
      xres_d = xResult;
      yres_d = yResult;
      zres_d = zResult;
    end
  end

  always_comb begin
    pending_d = pending_q;
    if (wr_acc && (req_idx == IDX_IRQSTAT) && reqWdata[0]) begin
      pending_d = 1'b0;
    end
    if (interrupt) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= BUS_IDLE;
      ctrl_q    <= CTRL_RESET_WORD;
      xin_q     <= '0;
      yin_q     <= '0;
      zin_q     <= '0;
      xres_q    <= '0;
      yres_q    <= '0;
      zres_q    <= '0;
      pending_q <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      xin_q     <= xin_d;
      yin_q     <= yin_d;
      zin_q     <= zin_d;
      xres_q    <= xres_d;
      yres_q    <= yres_d;
      zres_q    <= zres_d;
      pending_q <= pending_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign rspRdata             = rdata_q;
  assign rspErr               = err_q;
  assign controlRegisterInput = ctrl_q;
  assign xInput               = xin_q;
  assign yInput               = yin_q;
  assign zInput               = zin_q;
  assign irq                  = pending_q;

endmodule

// File: tb/tb_cordic_bus_regs.sv
// tb/tb_cordic_bus_regs.sv - randomized bench with a word-array reference model
module tb_cordic_bus_regs;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic        reqWrite = 1'b0;
  logic [4:0]  reqAddr = '0;
  logic [31:0] reqWdata = '0;
  logic        rspValid;
  logic        rspReady = 1'b1;
  logic [31:0] rspRdata;
  logic        rspErr;
  logic [31:0] controlRegisterInput;
  logic [31:0] xInput, yInput, zInput;
  logic [31:0] controlRegisterOutput = '0;
  logic        controlRegisterWriteEnable = 1'b0;
  logic [31:0] xResult = '0, yResult = '0, zResult = '0;
  logic        interrupt = 1'b0;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;
  bit bg_en = 1'b0;

  always #5 clk = ~clk;

  cordic_bus_regs #(.p_WIDTH(32), .p_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqAddr(reqAddr), .reqWdata(reqWdata),
    .rspValid(rspValid), .rspReady(rspReady), .rspRdata(rspRdata), .rspErr(rspErr),
    .controlRegisterInput(controlRegisterInput),
    .xInput(xInput), .yInput(yInput), .zInput(zInput),
    .controlRegisterOutput(controlRegisterOutput),
    .controlRegisterWriteEnable(controlRegisterWriteEnable),
    .xResult(xResult), .yResult(yResult), .zResult(zResult),
    .interrupt(interrupt), .irq(irq)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: eight words, a pending bit and one outstanding response slot.
  logic [31:0] m_reg [8];
  logic        m_pend;
  logic        m_busy;
  logic [31:0] m_data;
  logic        m_err;

  function automatic logic [31:0] m_read(input int idx);
    return (idx == 7) ? {31'b0, m_pend} : m_reg[idx];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) m_reg[i] = 32'h0;
      m_reg[0] = 32'h0001_3FF0;
      m_pend = 1'b0;
      m_busy = 1'b0;
      m_data = 32'h0;
      m_err  = 1'b0;
    end else begin
      int  idx;
      bit  acc;
      bit  clr;
      idx = int'(reqAddr[4:2]);
      acc = !m_busy && reqValid;
      clr = 1'b0;
      if (m_busy) begin
        if (rspReady) m_busy = 1'b0;
      end else if (reqValid) begin
        m_busy = 1'b1;
        m_err  = reqWrite && (idx >= 4) && (idx <= 6);
        m_data = reqWrite ? 32'h0 : m_read(idx);
      end
      if (controlRegisterWriteEnable) begin
        m_reg[0] = controlRegisterOutput;
        if (controlRegisterOutput[16]) begin
          m_reg[4] = xResult;
          m_reg[5] = yResult;
          m_reg[6] = zResult;
        end
      end
      if (acc && reqWrite) begin
        if (idx == 0) m_reg[0][15:0] = reqWdata[15:0];
        else if (idx >= 1 && idx <= 3) m_reg[idx] = reqWdata;
        else if (idx == 7) clr = reqWdata[0];
      end
      if (interrupt) m_pend = 1'b1;
      else if (clr) m_pend = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("reqReady", {31'b0, reqReady}, {31'b0, !m_busy});
      chk("rspValid", {31'b0, rspValid}, {31'b0, m_busy});
      if (m_busy) begin
        chk("rspRdata", rspRdata, m_data);
        chk("rspErr", {31'b0, rspErr}, {31'b0, m_err});
      end
      chk("ctrl_out", controlRegisterInput, m_reg[0]);
      chk("xInput", xInput, m_reg[1]);
      chk("yInput", yInput, m_reg[2]);
      chk("zInput", zInput, m_reg[3]);
      chk("irq", {31'b0, irq}, {31'b0, m_pend});
    end
  end

  always @(posedge clk) begin
    #1;
    if (bg_en) begin
      interrupt                  = ($urandom_range(7) == 0);
      controlRegisterWriteEnable = ($urandom_range(5) == 0);
      controlRegisterOutput      = $urandom;
      xResult                    = $urandom;
      yResult                    = $urandom;
      zResult                    = $urandom;
    end
  end

  // Called one time unit after a rising edge with the bank idle; returns the same way.
  task automatic bus(input logic wr, input logic [4:0] a, input logic [31:0] wd,
                     input bit rnd, output logic [31:0] rd, output logic err);
    int n;
    reqValid = 1'b1; reqWrite = wr; reqAddr = a; reqWdata = wd;
    rspReady = rnd ? 1'($urandom_range(1)) : 1'b1;
    @(posedge clk); #1;
    reqValid = 1'b0;
    rd = 32'h0; err = 1'b0; n = 0;
    forever begin
      @(negedge clk);
      if (rspValid && rspReady) begin
        rd = rspRdata; err = rspErr;
        @(posedge clk); #1;
        break;
      end
      n++;
      if (n > 20) begin
        chk("rsp_timeout", 32'h0, 32'h1);
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      if (rnd) rspReady = 1'($urandom_range(1));
      else rspReady = 1'b1;
    end
    rspReady = 1'b1;
  endtask

  task automatic pulse_wb(input logic [31:0] cro, input logic irq_in);
    controlRegisterWriteEnable = 1'b1; controlRegisterOutput = cro; interrupt = irq_in;
    @(posedge clk); #1;
    controlRegisterWriteEnable = 1'b0; interrupt = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  logic [31:0] exp_rst [8];

  initial begin
    exp_rst[0] = 32'h0001_3FF0;
    for (int i = 1; i < 8; i++) exp_rst[i] = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      bus(1'b0, 5'(i * 4), 32'h0, 1'b0, rd, er);
      chk("reset_read", rd, exp_rst[i]);
      chk("reset_err", {31'b0, er}, 32'h0);
    end
    chk("reset_irq", {31'b0, irq}, 32'h0);

    bus(1'b1, 5'h00, 32'hFFFF_0000, 1'b0, rd, er);
    bus(1'b0, 5'h00, 32'h0, 1'b0, rd, er);
    chk("flag_owner", rd, 32'h0001_0000);

    bus(1'b1, 5'h04, 32'h2000_0000, 1'b0, rd, er);
    chk("xin_visible", xInput, 32'h2000_0000);
    bus(1'b1, 5'h00, 32'h0000_3FF5, 1'b0, rd, er);
    chk("start_set", controlRegisterInput, 32'h0001_3FF5);
    pulse_wb(32'h0000_3FF4, 1'b0);
    chk("start_cleared", controlRegisterInput, 32'h0000_3FF4);

    reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 5'h00; reqWdata = 32'h0000_0002;
    controlRegisterWriteEnable = 1'b1; controlRegisterOutput = 32'h0001_3FF4;
    @(posedge clk); #1;
    reqValid = 1'b0; controlRegisterWriteEnable = 1'b0;
    @(posedge clk); #1;
    chk("collision", controlRegisterInput, 32'h0001_0002);

    xResult = 32'h1234_5678; yResult = 32'h0BAD_0001; zResult = 32'h0BAD_0002;
    pulse_wb(32'h0001_0000, 1'b1);
    xResult = 32'hDEAD_BEEF; yResult = 32'hDEAD_BEEF; zResult = 32'hDEAD_BEEF;
    chk("irq_set", {31'b0, irq}, 32'h1);
    bus(1'b0, 5'h10, 32'h0, 1'b0, rd, er);
    chk("xres_read", rd, 32'h1234_5678);
    bus(1'b0, 5'h1C, 32'h0, 1'b0, rd, er);
    chk("irqstat_read", rd, 32'h1);
    bus(1'b1, 5'h1C, 32'h1, 1'b0, rd, er);
    chk("irq_cleared", {31'b0, irq}, 32'h0);
    reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 5'h1C; reqWdata = 32'h1; interrupt = 1'b1;
    @(posedge clk); #1;
    reqValid = 1'b0; interrupt = 1'b0;
    @(posedge clk); #1;
    chk("set_beats_clear", {31'b0, irq}, 32'h1);
    bus(1'b1, 5'h1C, 32'h1, 1'b0, rd, er);
    chk("irq_cleared2", {31'b0, irq}, 32'h0);

    bus(1'b1, 5'h14, 32'hFFFF_FFFF, 1'b0, rd, er);
    chk("ro_write_err", {31'b0, er}, 32'h1);
    chk("ro_write_rdata", rd, 32'h0);
    bus(1'b1, 5'h18, 32'hFFFF_FFFF, 1'b0, rd, er);
    bus(1'b0, 5'h14, 32'h0, 1'b0, rd, er);
    chk("yres_kept", rd, 32'h0BAD_0001);
    bus(1'b0, 5'h18, 32'h0, 1'b0, rd, er);
    chk("zres_kept", rd, 32'h0BAD_0002);

    reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 5'h10; rspReady = 1'b0;
    @(posedge clk); #1;
    reqValid = 1'b0;
    xResult = 32'h5555_5555;
    controlRegisterWriteEnable = 1'b1; controlRegisterOutput = 32'h0001_0000;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("bp_valid", {31'b0, rspValid}, 32'h1);
      chk("bp_rdata", rspRdata, 32'h1234_5678);
      chk("bp_ready", {31'b0, reqReady}, 32'h0);
      @(posedge clk); #1;
      controlRegisterWriteEnable = 1'b0;
    end
    rspReady = 1'b1;
    @(posedge clk); #1;
    bus(1'b0, 5'h10, 32'h0, 1'b0, rd, er);
    chk("xres_new", rd, 32'h5555_5555);

    reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 5'h04; rspReady = 1'b0;
    @(posedge clk); #1;
    reqValid = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", {31'b0, rspValid}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("rst_drops_rsp", {31'b0, rspValid}, 32'h0);
    chk("rst_ready", {31'b0, reqReady}, 32'h1);
    chk("rst_ctrl", controlRegisterInput, 32'h0001_3FF0);
    @(posedge clk); #1;
    rst = 1'b0; rspReady = 1'b1;
    @(posedge clk); #1;
    chk("no_rsp_after_rst", {31'b0, rspValid}, 32'h0);
    bus(1'b0, 5'h04, 32'h0, 1'b0, rd, er);
    chk("xin_after_rst", rd, 32'h0);

    bg_en = 1'b1;
    for (int t = 0; t < 400; t++) begin
      bus(1'($urandom_range(1)), 5'($urandom_range(31)), $urandom, 1'b1, rd, er);
      repeat ($urandom_range(2)) @(posedge clk);
      #0;
    end
    bg_en = 1'b0;
    @(posedge clk); #1;
    controlRegisterWriteEnable = 1'b0; interrupt = 1'b0;
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cordic_bus_regs.md
# cordic_bus_regs

Memory-mapped register bank between the host bus and the CORDIC controller. It terminates a single-outstanding request/response bus and holds the control word and the X/Y/Z operands that drive the controller inputs. It also absorbs the controller's control-word write-backs, snapshots the results on completion, and turns the controller's one-cycle interrupt pulse into a sticky, software-cleared interrupt line.

## Interface
- p_WIDTH, 32, data and operand width
- p_ADDR_WIDTH, 5, byte address width; word index = reqAddr[4:2]

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- reqValid  in  1  bus request valid
- reqReady  out  1  bank can accept a request
- reqWrite  in  1  1 = write, 0 = read
- reqAddr  in  p_ADDR_WIDTH  byte address; bits [1:0] ignored
- reqWdata  in  p_WIDTH  write data
- rspValid  out  1  response valid
- rspReady  in  1  bus accepts the response
- rspRdata  out  p_WIDTH  read data; 0 on writes and errors
- rspErr  out  1  access error
- controlRegisterInput  out  32  stored control word, to the controller
- xInput, yInput, zInput  out  p_WIDTH  stored operands, to the controller
- controlRegisterOutput  in  32  control word written back by the controller
- controlRegisterWriteEnable  in  1  load controlRegisterOutput this cycle
- xResult, yResult, zResult  in  p_WIDTH  live controller datapath values
- interrupt  in  1  one-cycle completion/error pulse from the controller
- irq  out  1  sticky interrupt to the host

## Operation
**Word map** (index = reqAddr[4:2]):
- 0 CTRL: read/write
- 1 XIN, 2 YIN, 3 ZIN: read/write
- 4 XRES, 5 YRES, 6 ZRES: read-only
- 7 IRQSTAT: bit0 = pending; write-1-to-clear

**Bus FSM**, two states:
- IDLE: reqReady=1. On reqValid, perform the access and go to RESP.
- RESP: reqReady=0, rspValid=1. When rspReady=1, go to IDLE.
- rspErr=1 for any write to index 4-6. Such a write changes no state.

**CTRL ownership**
- Bits [31:16] (flags) are hardware-owned. Bus writes to them are ignored. They load only from controlRegisterOutput.
- Bits [15:0] load from the bus on a CTRL write and from controlRegisterOutput on controlRegisterWriteEnable.
- If both happen in the same cycle: [31:16] take the hardware value. [15:0] take the bus value, so a host START or STOP is never lost.

**START/STOP**
- The bank never self-clears START or STOP. The controller clears them through its write-back.

**Result snapshot**
- When controlRegisterWriteEnable=1 and controlRegisterOutput[16] (Ready)=1, capture xResult/yResult/zResult into XRES/YRES/ZRES.
- This also captures on the controller's reset write-back.

**Interrupt**
- interrupt=1 sets pending.
- An IRQSTAT write with bit0=1 clears pending.
- If set and clear happen in the same cycle, set wins.
- irq = pending.

## Timing
**Reset values**
- CTRL = 0x0001_3FF0: Ready=1, Z-OV report enable=1, iterations=31, interrupt and overflow-stop enables=1.
- XIN/YIN/ZIN/XRES/YRES/ZRES = 0; pending = 0.
- FSM = IDLE; reqReady=1; rspValid=0; rspRdata=0; rspErr=0; irq=0.

**Bus latency**
- Request accepted at edge N; rspValid is high from N+1 until rspReady.
- Sustained throughput is 1 transaction per 2 cycles.
- Read data is sampled at acceptance and held stable while rspValid=1. A hardware update during RESP does not alter rspRdata.

**Write visibility**
- A write becomes visible on controlRegisterInput, xInput, yInput and zInput the cycle after acceptance.
- Write the operands before the CTRL START write; the controller samples the operands on the same edge it sees START.

**Other timing**
- Snapshot registers and pending update on the edge where controlRegisterWriteEnable or interrupt is sampled high.
- irq rises one cycle after the interrupt pulse.
- rst asserted mid-transaction: drop the response immediately, return the FSM to IDLE, and load all reset values. No response is issued after reset.

## Structure
- Shared package cordic_pkg holds:
  - control and flag bit indices (START, STOP, ROT_MODE, ROT_SYS, enables, ITER_H/L, READY, error flags, ELAPS/OV_ITER fields);
  - word-index constants for the eight registers;
  - the CTRL reset word 0x0001_3FF0.
- The controller imports the same package.
- Single module; no sub-module is needed. The IRQ latch and bus FSM are small enough to live inline.

## Test plan
- **Reset defaults:** reset, read indices 0-7 → 0x0001_3FF0, 0, 0, 0, 0, 0, 0, 0; irq=0; rspErr=0.
- **Operand write and start:** write XIN=0x2000_0000, then CTRL=0x0000_3FF5 (start, circular, rotation) → xInput=0x2000_0000 next cycle; controlRegisterInput[0]=1 until controller write-back 0x0000_3FF4 clears it.
- **Flag ownership:** write CTRL=0xFFFF_0000 → read back has [31:16]=0x0001 and [15:0]=0x0000.
- **Collision:** bus CTRL write of 0x0000_0002 in the same cycle as write-back 0x0001_3FF4 → CTRL=0x0001_0002.
- **Completion:** write-back with bit16=1, xResult=0x1234_5678, plus an interrupt pulse → XRES reads 0x1234_5678; irq=1 until IRQSTAT write 0x1, then 0. Clear coinciding with a new pulse → irq stays 1.
- **Errors and backpressure:** write to index 5 → rspErr=1 and ZRES/YRES unchanged. Hold rspReady=0 for 4 cycles → rspValid and rspRdata stable, reqReady=0. Assert rst during RESP → rspValid=0 immediately.
